udp_tx_framer: RTL and testbench
================================

Name: udp_tx_framer

Overview:
- Builds complete Ethernet II / IPv4 / UDP frames around a fixed-length payload byte stream, e.g. ADC sample bytes.
- Drives the 8-bit transmit AXI-Stream input of the tri-mode Ethernet MAC (tx_axis_mac_*).
- Runs in the 125 MHz MAC clock domain and is the transmit-side producer that pairs with the MAC wrapper.
- Header fields come from parameters. IPv4 header checksum is computed per frame; UDP checksum is sent as 0x0000.

Parameters:
- SRC_MAC, 48'h02_00_00_00_00_01, source MAC address
- DST_MAC, 48'hFF_FF_FF_FF_FF_FF, destination MAC address
- SRC_IP, 32'hC0A8010A, source IPv4 (192.168.1.10)
- DST_IP, 32'hC0A80164, destination IPv4 (192.168.1.100)
- SRC_PORT, 16'd5000, UDP source port
- DST_PORT, 16'd5001, UDP destination port
- PAYLOAD_LEN, 1024, payload bytes per frame; legal range 1..1472 (1..1468 with the sequence-number option); checked by elaboration assertion

Ports:
- clk_125m  in  1  MAC transmit clock
- rst  in  1  asynchronous reset, active-high
- s_axis_tdata  in  8  payload byte
- s_axis_tvalid  in  1  payload valid
- s_axis_tlast  in  1  upstream end-of-payload marker
- s_axis_tready  out  1  payload accepted
- tx_axis_mac_tdata  out  8  frame byte to MAC
- tx_axis_mac_tvalid  out  1  frame byte valid
- tx_axis_mac_tlast  out  1  last frame byte
- tx_axis_mac_tuser  out  1  frame error/abort flag to MAC
- tx_axis_mac_tready  in  1  MAC accepts byte
- busy  out  1  frame in progress
- frame_sent  out  1  one-cycle pulse when the last byte is accepted
- len_err  out  1  one-cycle pulse on a tlast/length mismatch
- underrun  out  1  one-cycle pulse when payload is starved mid-frame

Behaviour:
- Reset: every output is 0, the state is IDLE, and the IP ID counter is 0. Reset is asynchronous, so asserting it mid-frame truncates the frame immediately.
- States:
  - IDLE
  - CSUM
  - HDR
  - PAYLOAD
- IDLE:
  - s_axis_tready=0.
  - When s_axis_tvalid=1, go to CSUM. The payload byte is not consumed.
- CSUM (1 cycle):
  - Register the IPv4 checksum: one's-complement sum of the ten header words, carries folded twice, result inverted.
  - IP total_len = 28 + L, where L is the effective payload length.
  - Then go to HDR with the byte index at 0.
- HDR: emit 42 bytes in this order:
  - DST_MAC[47:40] first, ... SRC_MAC, 0x08 0x00
  - 0x45 0x00, total_len, ip_id, 0x40 0x00, TTL 0x40, proto 0x11, checksum, SRC_IP, DST_IP
  - SRC_PORT, DST_PORT, udp_len = 8 + L, 0x00 0x00
  - All multi-byte fields are MSB first.
- MAC handshake:
  - tx_axis_mac_tvalid is held at 1 for the whole frame.
  - The index advances only when tvalid & tready.
  - tdata is stable while tready=0.
- Latency: first header byte is valid 2 cycles after s_axis_tvalid rises in IDLE.
- PAYLOAD:
  - Pass-through: s_axis_tready = tx_axis_mac_tready, tdata = s_axis_tdata.
  - The payload counter advances on the MAC handshake.
  - tlast=1 on payload byte L−1; when accepted, pulse frame_sent, increment ip_id (wraps 0xFFFF→0), and go to IDLE.
- Early s_axis_tlast (before byte L−1):
  - Pulse len_err.
  - Drop s_axis_tready and pad the rest of the payload with 0x00.
- Missing tlast at byte L−1:
  - Pulse len_err.
  - The frame still ends; following bytes start the next frame.
- Underrun, i.e. s_axis_tvalid=0 in PAYLOAD:
  - Frame bytes cannot be stalled, so emit 0x00 and pulse underrun.
  - Set tx_axis_mac_tuser=1 on this frame's tlast beat so the MAC drops the frame.
  - tuser is 0 otherwise.
- busy=1 in every state except IDLE.
- IP flags are DF. UDP checksum is always 0x0000. Minimum-frame padding is left to the MAC.

Optional Feature:
- Macro: UDP_TX_SEQNUM_EN.
- Defined: a 32-bit frame sequence counter (reset 0, increments on frame_sent) is inserted MSB first as the first 4 payload bytes, before the stream bytes. L = PAYLOAD_LEN + 4.
- Undefined: no insertion; L = PAYLOAD_LEN.

Decomposition:
- Package udp_pkg holds:
  - HDR_LEN=42, ETHERTYPE_IPV4=16'h0800, IP_PROTO_UDP=8'h11, IP_TTL=8'h40
  - state enum udp_tx_state_t
  - function ip_csum_fold
- Sub-module udp_ip_csum: registered one's-complement checksum over the ten header words, one cycle of latency; used in CSUM.

Test Plan:
- Defaults, PAYLOAD_LEN=8, tready=1, bytes 0x01..0x08 with tlast on 0x08 -> 50-byte frame; bytes 14..15 = 0x45 0x00; total_len=0x0024; checksum=0xB70A; udp_len=0x0010; tlast on byte 49; frame_sent pulses once.
- Second identical frame -> ip_id=0x0001, checksum=0xB709.
- tready toggled 1/0 pseudo-randomly through a frame -> byte sequence identical to the first case; tdata stable while stalled.
- PAYLOAD_LEN=8, tlast on the 5th byte -> bytes 6..8 are 0x00; len_err pulses; frame still 50 bytes; next frame correct.
- s_axis_tvalid dropped for 2 cycles mid-payload -> underrun pulses; 0x00 bytes inserted; tuser=1 with tlast.
- rst asserted at header byte 20 -> all outputs 0 asynchronously; after release the next frame starts at DST_MAC with ip_id=0.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared constants, FSM state type and IPv4 checksum folding helper for the
// UDP transmit framer.
package udp_pkg;

    localparam int unsigned HDR_LEN        = 42;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [7:0]  IP_TTL         = 8'h40;

    typedef enum logic [1:0] {
        IDLE,
        CSUM,
        HDR,
        PAYLOAD
    } udp_tx_state_t;

    // Two end-around-carry folds are enough for a sum of ten 16-bit words.
    function automatic logic [15:0] ip_csum_fold(input logic [19:0] sum);
        logic [16:0] s1;
        logic [16:0] s2;
        s1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
        s2 = {1'b0, s1[15:0]} + {16'd0, s1[16]};
        return s2[15:0];
    endfunction

endpackage

// File: rtl/udp_ip_csum.sv
// Registered IPv4 header checksum over the ten header words; the value is
// captured when en_i is high and held for the rest of the frame.
module udp_ip_csum
    import udp_pkg::*;
#(
    parameter logic [31:0] SRC_IP = 32'hC0A8010A,
    parameter logic [31:0] DST_IP = 32'hC0A80164
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [15:0] total_len_i,
    input  logic [15:0] ip_id_i,
    output logic [15:0] csum_o
);

    logic [19:0] sum;
    logic [15:0] csum_q;
    logic [15:0] csum_d;

    // The checksum word itself is zero during computation, so it is left out.
    always_comb begin
        sum = 20'h04500 + 20'(total_len_i) + 20'(ip_id_i) + 20'h04000
            + 20'({IP_TTL, IP_PROTO_UDP})
            + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0])
            + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
        csum_d = en_i ? ~ip_csum_fold(sum) : csum_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) csum_q <= '0;
        else       csum_q <= csum_d;
    end

    assign csum_o = csum_q;

endmodule

// File: rtl/udp_tx_framer.sv
// Ethernet II / IPv4 / UDP frame builder feeding the MAC transmit AXI-Stream.
// Optional macro UDP_TX_SEQNUM_EN prepends a 32-bit frame sequence number.
module udp_tx_framer
    import udp_pkg::*;
#(
    parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
    parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [31:0] SRC_IP      = 32'hC0A8010A,
    parameter logic [31:0] DST_IP      = 32'hC0A80164,
    parameter logic [15:0] SRC_PORT    = 16'd5000,
    parameter logic [15:0] DST_PORT    = 16'd5001,
    parameter int          PAYLOAD_LEN = 1024
) (
    input  logic       clk_125m,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tlast,
    output logic       s_axis_tready,
    output logic [7:0] tx_axis_mac_tdata,
    output logic       tx_axis_mac_tvalid,
    output logic       tx_axis_mac_tlast,
    output logic       tx_axis_mac_tuser,
    input  logic       tx_axis_mac_tready,
    output logic       busy,
    output logic       frame_sent,
    output logic       len_err,
    output logic       underrun
);

`ifdef UDP_TX_SEQNUM_EN
    localparam int SEQ_BYTES = 4;
`else
    localparam int SEQ_BYTES = 0;
`endif
    localparam int          EFF_LEN   = PAYLOAD_LEN + SEQ_BYTES;
    localparam logic [15:0] TOTAL_LEN = 16'(28 + EFF_LEN);
    localparam logic [15:0] UDP_LEN   = 16'(8 + EFF_LEN);
    localparam logic [10:0] LAST_IDX  = 11'(EFF_LEN - 1);

    generate
        if (PAYLOAD_LEN < 1 || PAYLOAD_LEN > 1472 - SEQ_BYTES) begin : g_len_chk
            $error("udp_tx_framer: PAYLOAD_LEN out of range");
        end
    endgenerate

    udp_tx_state_t state_q, state_d;
    logic [5:0]    hdr_idx_q, hdr_idx_d;
    logic [10:0]   pay_cnt_q, pay_cnt_d;
    logic [15:0]   ip_id_q, ip_id_d;
    logic          pad_q, pad_d;
    logic          err_q, err_d;
    logic          frame_sent_q, frame_sent_d;
    logic          len_err_q, len_err_d;
    logic          underrun_q, underrun_d;
    logic [15:0]   csum;
    logic [335:0]  hdr_vec;
    logic [7:0]    hdr_bytes [HDR_LEN];
    logic          in_seq;
    logic [7:0]    seq_byte;
    logic          starve;
    logic          pay_last;

    udp_ip_csum #(
        .SRC_IP (SRC_IP),
        .DST_IP (DST_IP)
    ) u_csum (
        .clk_i       (clk_125m),
        .rst_i       (rst),
        .en_i        (state_q == CSUM),
        .total_len_i (TOTAL_LEN),
        .ip_id_i     (ip_id_q),
        .csum_o      (csum)
    );

    assign hdr_vec = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4, 16'h4500, TOTAL_LEN, ip_id_q,
                      16'h4000, IP_TTL, IP_PROTO_UDP, csum, SRC_IP, DST_IP,
                      SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};

    always_comb begin
        for (int unsigned i = 0; i < HDR_LEN; i++) begin
            hdr_bytes[i] = hdr_vec[8*(HDR_LEN-1-i) +: 8];
        end
    end

`ifdef UDP_TX_SEQNUM_EN
    logic [31:0] seq_q, seq_d;
    assign in_seq = (pay_cnt_q < 11'd4);
    assign seq_d  = frame_sent_d ? seq_q + 32'd1 : seq_q;
    always_comb begin
        unique case (pay_cnt_q[1:0])
            2'd0:    seq_byte = seq_q[31:24];
            2'd1:    seq_byte = seq_q[23:16];
            2'd2:    seq_byte = seq_q[15:8];
            default: seq_byte = seq_q[7:0];
        endcase
    end
    always_ff @(posedge clk_125m or posedge rst) begin
        if (rst) seq_q <= '0;
        else     seq_q <= seq_d;
    end
`else
    assign in_seq   = 1'b0;
    assign seq_byte = '0;
`endif

    always_comb begin
        state_d      = state_q;
        hdr_idx_d    = hdr_idx_q;
        pay_cnt_d    = pay_cnt_q;
        ip_id_d      = ip_id_q;
        pad_d        = pad_q;
        err_d        = err_q;
        frame_sent_d = 1'b0;
        len_err_d    = 1'b0;
        underrun_d   = 1'b0;
        starve       = 1'b0;
        pay_last     = (pay_cnt_q == LAST_IDX);
        s_axis_tready      = 1'b0;
        tx_axis_mac_tvalid = 1'b0;
        tx_axis_mac_tdata  = '0;
        tx_axis_mac_tlast  = 1'b0;
        tx_axis_mac_tuser  = 1'b0;
        unique case (state_q)
            IDLE: if (s_axis_tvalid) state_d = CSUM;
            CSUM: begin
                state_d   = HDR;
                hdr_idx_d = '0;
            end
            HDR: begin
                tx_axis_mac_tvalid = 1'b1;
                tx_axis_mac_tdata  = hdr_bytes[hdr_idx_q];
                if (tx_axis_mac_tready) begin
                    if (hdr_idx_q == 6'(HDR_LEN - 1)) begin
                        state_d   = PAYLOAD;
                        pay_cnt_d = '0;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 6'd1;
                    end
                end
            end
            PAYLOAD: begin
                tx_axis_mac_tvalid = 1'b1;
                tx_axis_mac_tlast  = pay_last;
                if (in_seq) begin
                    tx_axis_mac_tdata = seq_byte;
                end else if (!pad_q) begin
                    s_axis_tready = tx_axis_mac_tready;
                    if (s_axis_tvalid) begin
                        tx_axis_mac_tdata = s_axis_tdata;
                        // tlast disagreeing with the byte position covers both early and missing tlast
                        if (tx_axis_mac_tready && (s_axis_tlast != pay_last)) begin
                            len_err_d = 1'b1;
                            pad_d     = s_axis_tlast;
                        end
                    end else begin
                        starve = 1'b1;
                    end
                end
                tx_axis_mac_tuser = pay_last & (err_q | starve);
                if (tx_axis_mac_tready) begin
                    pay_cnt_d  = pay_cnt_q + 11'd1;
                    underrun_d = starve;
                    err_d      = err_q | starve;
                    if (pay_last) begin
                        state_d      = IDLE;
                        frame_sent_d = 1'b1;
                        ip_id_d      = ip_id_q + 16'd1;
                        pad_d        = 1'b0;
                        err_d        = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_125m or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hdr_idx_q    <= '0;
            pay_cnt_q    <= '0;
            ip_id_q      <= '0;
            pad_q        <= 1'b0;
            err_q        <= 1'b0;
            frame_sent_q <= 1'b0;
            len_err_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_idx_q    <= hdr_idx_d;
            pay_cnt_q    <= pay_cnt_d;
            ip_id_q      <= ip_id_d;
            pad_q        <= pad_d;
            err_q        <= err_d;
            frame_sent_q <= frame_sent_d;
            len_err_q    <= len_err_d;
            underrun_q   <= underrun_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign frame_sent = frame_sent_q;
    assign len_err    = len_err_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Self-checking bench for udp_tx_framer (PAYLOAD_LEN=8, sequence option off):
// header table, directed corner sequences and randomized stream traffic.
module tb_udp_tx_framer;

    localparam int L = 8;

    logic       clk_125m = 1'b0;
    logic       rst;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tlast;
    logic       s_axis_tready;
    logic [7:0] tx_axis_mac_tdata;
    logic       tx_axis_mac_tvalid;
    logic       tx_axis_mac_tlast;
    logic       tx_axis_mac_tuser;
    logic       tx_axis_mac_tready;
    logic       busy, frame_sent, len_err, underrun;

    udp_tx_framer #(.PAYLOAD_LEN(L)) dut (
        .clk_125m           (clk_125m),
        .rst                (rst),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tready      (s_axis_tready),
        .tx_axis_mac_tdata  (tx_axis_mac_tdata),
        .tx_axis_mac_tvalid (tx_axis_mac_tvalid),
        .tx_axis_mac_tlast  (tx_axis_mac_tlast),
        .tx_axis_mac_tuser  (tx_axis_mac_tuser),
        .tx_axis_mac_tready (tx_axis_mac_tready),
        .busy               (busy),
        .frame_sent         (frame_sent),
        .len_err            (len_err),
        .underrun           (underrun)
    );

    always #4 clk_125m = ~clk_125m;

    typedef struct { logic [7:0] data; logic last; int unsigned gap; } beat_t;
    typedef struct { logic [7:0] data; logic last; logic user; } obeat_t;
    typedef struct { int idx; logic [7:0] exp; } vec_t;

    beat_t       src_q[$];
    beat_t       mdl_q[$];
    obeat_t      out_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  mdl_pl[$];
    logic [15:0] mdl_ip_id = 16'd0;
    int checks = 0, errors = 0;
    int n_sent = 0, n_lerr = 0, n_urun = 0, frames_done = 0;
    bit src_hs = 1'b0, rand_ready = 1'b0, stall_pend = 1'b0;
    logic [7:0] stall_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: frame = header built from field values + payload
    function automatic void push_be(input longint unsigned v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
    endfunction

    function automatic void build_frame();
        int unsigned sum;
        logic [15:0] cs;
        exp_q.delete();
        push_be(64'hFFFF_FFFF_FFFF, 6); push_be(64'h02_00_00_00_00_01, 6); push_be(64'h0800, 2);
        push_be(64'h45, 1); push_be(0, 1); push_be(longint'(28 + mdl_pl.size()), 2);
        push_be(longint'(mdl_ip_id), 2); push_be(64'h40, 1); push_be(0, 1);
        push_be(64'h40, 1); push_be(64'h11, 1); push_be(0, 2);
        push_be(64'hC0A8010A, 4); push_be(64'hC0A80164, 4);
        push_be(5000, 2); push_be(5001, 2); push_be(longint'(8 + mdl_pl.size()), 2); push_be(0, 2);
        sum = 0;
        for (int i = 14; i < 34; i += 2) sum += {16'd0, exp_q[i], exp_q[i+1]};
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        cs = ~sum[15:0];
        exp_q[24] = cs[15:8];
        exp_q[25] = cs[7:0];
        foreach (mdl_pl[i]) exp_q.push_back(mdl_pl[i]);
    endfunction

    // Stream-level framing rule: L bytes per frame, zero pad after early tlast.
    function automatic bit take_frame();
        bit pad = 1'b0, lerr = 1'b0;
        beat_t b;
        mdl_pl.delete();
        for (int k = 0; k < L; k++) begin
            if (pad || mdl_q.size() == 0) mdl_pl.push_back(8'h00);
            else begin
                b = mdl_q.pop_front();
                mdl_pl.push_back(b.data);
                if (b.last && k < L - 1) begin lerr = 1'b1; pad = 1'b1; end
                if (!b.last && k == L - 1) lerr = 1'b1;
            end
        end
        return lerr;
    endfunction

    task automatic push_beat(input logic [7:0] d, input bit last, input int unsigned gap, input bit to_model);
        beat_t b;
        b.data = d; b.last = last; b.gap = gap;
        src_q.push_back(b);
        if (to_model) mdl_q.push_back(b);
    endtask

    task automatic compare_frame(input string name, input bit exp_user);
        obeat_t got[$];
        obeat_t o;
        int n;
        while (out_q.size() > 0) begin
            o = out_q.pop_front();
            got.push_back(o);
            if (o.last) break;
        end
        check($sformatf("%s length", name), got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s byte%0d", name, i), got[i].data, exp_q[i]);
            check($sformatf("%s last/user%0d", name, i), {got[i].last, got[i].user},
                  (i == exp_q.size() - 1) ? {1'b1, exp_user} : 2'b00);
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin @(negedge clk_125m); n++; end
        check("frames completed", frames_done, target);
        repeat (3) @(negedge clk_125m);
    endtask

    // Monitor: capture accepted frame bytes, pulse counts, stall stability
    initial forever begin
        obeat_t o;
        @(negedge clk_125m);
        src_hs = s_axis_tvalid && s_axis_tready;
        if (rst) stall_pend = 1'b0;
        else begin
            if (tx_axis_mac_tvalid) begin
                if (stall_pend) check("stall stable", tx_axis_mac_tdata, stall_data);
                stall_pend = !tx_axis_mac_tready;
                stall_data = tx_axis_mac_tdata;
                if (tx_axis_mac_tready) begin
                    o.data = tx_axis_mac_tdata; o.last = tx_axis_mac_tlast; o.user = tx_axis_mac_tuser;
                    out_q.push_back(o);
                    if (tx_axis_mac_tlast) frames_done++;
                end
            end else stall_pend = 1'b0;
            if (frame_sent) n_sent++;
            if (len_err)    n_lerr++;
            if (underrun)   n_urun++;
        end
    end

    // Upstream source and MAC ready driver
    initial begin
        s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; s_axis_tlast = 1'b0; tx_axis_mac_tready = 1'b1;
        forever begin
            @(posedge clk_125m); #1;
            if (src_hs && src_q.size() > 0) void'(src_q.pop_front());
            src_hs = 1'b0;
            if (rst || src_q.size() == 0) begin
                s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; s_axis_tlast = 1'b0;
            end else if (src_q[0].gap > 0) begin
                s_axis_tvalid = 1'b0;
                src_q[0].gap = src_q[0].gap - 1;
            end else begin
                s_axis_tvalid = 1'b1; s_axis_tdata = src_q[0].data; s_axis_tlast = src_q[0].last;
            end
            tx_axis_mac_tready = rand_ready ? ($urandom_range(1) != 0) : 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl [29] = '{
            '{0, 8'hFF}, '{5, 8'hFF}, '{6, 8'h02}, '{11, 8'h01}, '{12, 8'h08}, '{13, 8'h00},
            '{14, 8'h45}, '{15, 8'h00}, '{16, 8'h00}, '{17, 8'h24}, '{18, 8'h00}, '{19, 8'h00},
            '{20, 8'h40}, '{22, 8'h40}, '{23, 8'h11}, '{24, 8'hB7}, '{25, 8'h0A}, '{26, 8'hC0},
            '{29, 8'h0A}, '{33, 8'h64}, '{34, 8'h13}, '{35, 8'h88}, '{36, 8'h13}, '{37, 8'h89},
            '{38, 8'h00}, '{39, 8'h10}, '{41, 8'h00}, '{42, 8'h01}, '{49, 8'h08}};
        int lat, n, b_sent, b_lerr, b_urun, nfr, exp_lerr, len;
        beat_t save[$];

        rst = 1'b1;
        repeat (2) @(negedge clk_125m);
        check("reset outputs", {s_axis_tready, tx_axis_mac_tvalid, tx_axis_mac_tdata, tx_axis_mac_tlast,
              tx_axis_mac_tuser, busy, frame_sent, len_err, underrun}, 16'h0000);
        rst = 1'b0;
        repeat (2) @(negedge clk_125m);
        check("idle busy", busy, 1'b0);

        // Basic frame, header table, latency
        for (int i = 1; i <= 8; i++) push_beat(8'(i), i == 8, 0, 1'b1);
        n = 0;
        while (!s_axis_tvalid && n < 20) begin @(negedge clk_125m); n++; end
        check("idle tready", s_axis_tready, 1'b0);
        lat = 0;
        while (!tx_axis_mac_tvalid && lat < 20) begin @(negedge clk_125m); lat++; end
        check("first byte latency", lat, 2);
        wait_frames(1, 300);
        for (int i = 0; i < 29; i++)
            check($sformatf("tbl byte%0d", tbl[i].idx),
                  (out_q.size() > tbl[i].idx) ? out_q[tbl[i].idx].data : 8'hxx, tbl[i].exp);
        check("f1 len_err model", take_frame(), 1'b0);
        build_frame(); compare_frame("f1", 1'b0); mdl_ip_id++;
        check("f1 frame_sent count", n_sent, 1);
        check("f1 len_err count", n_lerr, 0);

        // Second frame: ip_id and checksum move
        for (int i = 1; i <= 8; i++) push_beat(8'(i), i == 8, 0, 1'b1);
        wait_frames(2, 300);
        check("f2 ip_id", (out_q.size() > 25) ? {out_q[18].data, out_q[19].data} : 16'hxxxx, 16'h0001);
        check("f2 checksum", (out_q.size() > 25) ? {out_q[24].data, out_q[25].data} : 16'hxxxx, 16'hB709);
        void'(take_frame()); build_frame(); compare_frame("f2", 1'b0); mdl_ip_id++;

        // MAC backpressure
        rand_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_beat(8'(i), i == 8, 0, 1'b1);
        wait_frames(3, 600);
        rand_ready = 1'b0;
        void'(take_frame()); build_frame(); compare_frame("f3 stalled", 1'b0); mdl_ip_id++;

        // Early tlast on 5th byte, then a normal frame
        b_lerr = n_lerr;
        for (int i = 1; i <= 5; i++) push_beat(8'(8'h10 + i), i == 5, 0, 1'b1);
        for (int i = 1; i <= 8; i++) push_beat(8'(8'h20 + i), i == 8, 0, 1'b1);
        wait_frames(5, 600);
        check("early len_err model", take_frame(), 1'b1);
        check("early pad bytes", {mdl_pl[5], mdl_pl[6], mdl_pl[7]}, 24'h000000);
        build_frame(); compare_frame("early", 1'b0); mdl_ip_id++;
        void'(take_frame()); build_frame(); compare_frame("after early", 1'b0); mdl_ip_id++;
        check("early len_err pulses", n_lerr - b_lerr, 1);

        // Two-cycle underrun before the 4th stream byte
        b_urun = n_urun; b_lerr = n_lerr;
        for (int i = 1; i <= 6; i++) push_beat(8'(8'hA0 + i), i == 6, (i == 4) ? 2 : 0, 1'b0);
        wait_frames(6, 300);
        mdl_pl = '{8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'hA4, 8'hA5, 8'hA6};
        build_frame(); compare_frame("underrun", 1'b1); mdl_ip_id++;
        check("underrun pulses", n_urun - b_urun, 2);
        check("underrun len_err", n_lerr - b_lerr, 0);

        // Randomized stream: packets of 1..L+3 bytes, random MAC ready
        b_sent = n_sent; b_lerr = n_lerr;
        rand_ready = 1'b1;
        for (int p = 0; p < 30; p++) begin
            len = $urandom_range(L + 3, 1);
            for (int i = 0; i < len; i++) push_beat(8'($urandom), i == len - 1, 0, 1'b1);
        end
        save = mdl_q; nfr = 0; exp_lerr = 0;
        while (mdl_q.size() > 0) begin exp_lerr += int'(take_frame()); nfr++; end
        mdl_q = save;
        wait_frames(6 + nfr, 20000);
        rand_ready = 1'b0;
        for (int f = 0; f < nfr; f++) begin
            void'(take_frame()); build_frame(); compare_frame($sformatf("rnd%0d", f), 1'b0); mdl_ip_id++;
        end
        check("rnd frame_sent pulses", n_sent - b_sent, nfr);
        check("rnd len_err pulses", n_lerr - b_lerr, exp_lerr);

        // Asynchronous reset while header byte 20 is on the bus
        out_q.delete();
        for (int i = 1; i <= 8; i++) push_beat(8'(i), i == 8, 0, 1'b0);
        n = 0;
        while (out_q.size() < 20 && n < 200) begin @(negedge clk_125m); n++; end
        check("reached hdr byte20", out_q.size(), 20);
        #1 rst = 1'b1;
        #1;
        check("async reset outputs", {s_axis_tready, tx_axis_mac_tvalid, tx_axis_mac_tdata, tx_axis_mac_tlast,
              tx_axis_mac_tuser, busy, frame_sent, len_err, underrun}, 16'h0000);
        src_q.delete(); mdl_q.delete(); out_q.delete(); src_hs = 1'b0;
        mdl_ip_id = 16'd0;
        n = frames_done;
        repeat (2) @(negedge clk_125m);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) push_beat(8'(8'h30 + i), i == 8, 0, 1'b1);
        wait_frames(n + 1, 300);
        void'(take_frame()); build_frame(); compare_frame("post reset", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
